// File: rtl/perf_pkg.sv
// Shared definitions for the performance-counter block:
// register indices, CTRL bit positions, ID constant, bus FSM states.
package perf_pkg;

    localparam int NUM_CNT = 5;

    localparam logic [2:0] REG_CYC    = 3'd0;
    localparam logic [2:0] REG_INS    = 3'd1;
    localparam logic [2:0] REG_BRT    = 3'd2;
    localparam logic [2:0] REG_JMP    = 3'd3;
    localparam logic [2:0] REG_JRG    = 3'd4;
    localparam logic [2:0] REG_CTRL   = 3'd5;
    localparam logic [2:0] REG_STATUS = 3'd6;
    localparam logic [2:0] REG_ID     = 3'd7;

    localparam int CTRL_EN  = 0;
    localparam int CTRL_CLR = 1;
    localparam int CTRL_IRQ = 2;

    localparam logic [31:0] ID_VALUE = 32'h5043_0001;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACK  = 2'd1,
        ST_HOLD = 2'd2
    } bus_state_e;

endpackage

// File: rtl/perf_event_counter.sv
// One wrapping event counter with clear / load / increment priority.
// Ports: clk, rst (async, active-low), inc, ld, ld_val, clr -> count, wrap.
module perf_event_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             ld,
    input  logic [CNT_W-1:0] ld_val,
    input  logic             clr,
    output logic [CNT_W-1:0] count,
    output logic             wrap
);

    // High during the cycle whose edge rolls the count from all-ones to 0;
    // a clear or load on that edge wins, so no wrap is reported.
    assign wrap = inc & ~ld & ~clr & (&count);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (ld) begin
            count <= ld_val;
        end else if (inc) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/perf_counter_unit.sv
// Performance counters (CYC/INS/BRT/JMP/JRG) with a 4-phase req/ack register port.
// Ports: core strobes in, bus_req/we/addr/wdata in, bus_ack/rdata and ovf_irq out.
module perf_counter_unit
    import perf_pkg::*;
#(
    parameter int CNT_W       = 32,
    parameter bit IRQ_DEFAULT = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_valid,
    input  logic        branch_taken,
    input  logic        jump,
    input  logic        jump_reg,
    input  logic        bus_req,
    input  logic        bus_we,
    input  logic [2:0]  bus_addr,
    input  logic [31:0] bus_wdata,
    output logic        bus_ack,
    output logic [31:0] bus_rdata,
    output logic        ovf_irq
);

    bus_state_e state;
    bus_state_e state_next;

    logic access;
    logic wr;
    logic rd;
    logic clr;

    logic en;
    logic en_next;
    logic irq_en;
    logic irq_en_next;

    logic [4:0] status;
    logic [4:0] status_next;

    logic [NUM_CNT-1:0] event_hit;
    logic [NUM_CNT-1:0] inc;
    logic [NUM_CNT-1:0] ld;
    logic [NUM_CNT-1:0] wrap;
    logic [CNT_W-1:0]   count [NUM_CNT];

    logic [31:0] read_val;

    // Bus handshake: one access per req high-phase, performed on leaving IDLE.
    always_comb begin
        state_next = state;
        access     = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (bus_req) begin
                    access     = 1'b1;
                    state_next = ST_ACK;
                end
            end
            ST_ACK: begin
                state_next = bus_req ? ST_HOLD : ST_IDLE;
            end
            ST_HOLD: begin
                if (!bus_req) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign wr      = access & bus_we;
    assign rd      = access & ~bus_we;
    assign bus_ack = (state != ST_IDLE);

    assign clr = wr && (bus_addr == REG_CTRL) && bus_wdata[CTRL_CLR];

    // CYC always fires; the rest only for a retiring instruction.
    assign event_hit = {
        instr_valid & jump_reg,
        instr_valid & jump,
        instr_valid & branch_taken,
        instr_valid,
        1'b1
    };
    assign inc = event_hit & {NUM_CNT{en}};

    for (genvar i = 0; i < NUM_CNT; i++) begin : g_cnt
        assign ld[i] = wr && (bus_addr == 3'(i));

        perf_event_counter #(
            .CNT_W (CNT_W)
        ) u_cnt (
            .clk    (clk),
            .rst    (rst),
            .inc    (inc[i]),
            .ld     (ld[i]),
            .ld_val (bus_wdata[CNT_W-1:0]),
            .clr    (clr),
            .count  (count[i]),
            .wrap   (wrap[i])
        );
    end

    always_comb begin
        en_next     = en;
        irq_en_next = irq_en;
        if (wr && (bus_addr == REG_CTRL)) begin
            en_next     = bus_wdata[CTRL_EN];
            irq_en_next = bus_wdata[CTRL_IRQ];
        end
    end

    // A wrap on the same edge as a W1C keeps the bit set.
    always_comb begin
        status_next = status;
        if (wr && (bus_addr == REG_STATUS)) begin
            status_next = status & ~bus_wdata[4:0];
        end
        status_next = status_next | wrap;
    end

    always_comb begin
        read_val = '0;
        unique case (bus_addr)
            REG_CYC:    read_val = 32'(count[0]);
            REG_INS:    read_val = 32'(count[1]);
            REG_BRT:    read_val = 32'(count[2]);
            REG_JMP:    read_val = 32'(count[3]);
            REG_JRG:    read_val = 32'(count[4]);
            REG_CTRL: begin
                read_val[CTRL_EN]  = en;
                read_val[CTRL_IRQ] = irq_en;
            end
            REG_STATUS: read_val[4:0] = status;
            REG_ID:     read_val = ID_VALUE;
            default:    read_val = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            bus_rdata <= '0;
            en        <= 1'b1;
            irq_en    <= IRQ_DEFAULT;
            status    <= '0;
            ovf_irq   <= 1'b0;
        end else begin
            state   <= state_next;
            en      <= en_next;
            irq_en  <= irq_en_next;
            status  <= status_next;
            ovf_irq <= (|status_next) & irq_en_next;
            if (rd) begin
                bus_rdata <= read_val;
            end else if (state_next == ST_IDLE) begin
                bus_rdata <= '0;
            end
        end
    end

endmodule

// File: tb/tb_perf_counter_unit.sv
// Self-checking bench for perf_counter_unit: directed scenarios plus
// randomized traffic compared every cycle against a behavioural model.
module tb_perf_counter_unit;

    localparam int     CNT_W = 32;
    localparam longint MAXV  = (longint'(1) << CNT_W) - 1;
    localparam logic [31:0] ID_CONST = 32'h5043_0001;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_valid;
    logic        branch_taken;
    logic        jump;
    logic        jump_reg;
    logic        bus_req;
    logic        bus_we;
    logic [2:0]  bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;
    logic        ovf_irq;

    perf_counter_unit #(
        .CNT_W       (CNT_W),
        .IRQ_DEFAULT (1'b0)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .instr_valid  (instr_valid),
        .branch_taken (branch_taken),
        .jump         (jump),
        .jump_reg     (jump_reg),
        .bus_req      (bus_req),
        .bus_we       (bus_we),
        .bus_addr     (bus_addr),
        .bus_wdata    (bus_wdata),
        .bus_ack      (bus_ack),
        .bus_rdata    (bus_rdata),
        .ovf_irq      (ovf_irq)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Reference model: plain integer tallies and flags.
    longint      m_cnt [5];
    bit          m_en;
    bit          m_irq_en;
    bit [4:0]    m_st;
    bit          m_irq;
    bit          m_busy;
    logic [31:0] m_rdata;

    task automatic model_reset();
        for (int i = 0; i < 5; i++) m_cnt[i] = 0;
        m_en     = 1'b1;
        m_irq_en = 1'b0;
        m_st     = '0;
        m_irq    = 1'b0;
        m_busy   = 1'b0;
        m_rdata  = '0;
    endtask

    function automatic logic [31:0] m_read(input logic [2:0] a);
        logic [31:0] v;
        v = '0;
        if (a < 3'd5) v = 32'(m_cnt[a]);
        else if (a == 3'd5) v = {29'd0, m_irq_en, 1'b0, m_en};
        else if (a == 3'd6) v = {27'd0, m_st};
        else v = ID_CONST;
        return v;
    endfunction

    task automatic model_edge();
        bit       acc;
        bit       wr;
        bit [4:0] ev;
        bit [4:0] wraps;
        acc = bus_req && !m_busy;
        wr  = acc && bus_we;
        ev  = {instr_valid & jump_reg, instr_valid & jump,
               instr_valid & branch_taken, instr_valid, 1'b1};
        if (acc && !bus_we) m_rdata = m_read(bus_addr);
        else if (m_busy && !bus_req) m_rdata = '0;
        wraps = '0;
        for (int i = 0; i < 5; i++) begin
            if (wr && bus_addr == 3'd5 && bus_wdata[1]) begin
                m_cnt[i] = 0;
            end else if (wr && bus_addr == 3'(i)) begin
                m_cnt[i] = longint'(bus_wdata) & MAXV;
            end else if (m_en && ev[i]) begin
                if (m_cnt[i] == MAXV) begin
                    m_cnt[i] = 0;
                    wraps[i] = 1'b1;
                end else begin
                    m_cnt[i] = m_cnt[i] + 1;
                end
            end
        end
        if (wr && bus_addr == 3'd6) m_st = m_st & ~bus_wdata[4:0];
        m_st = m_st | wraps;
        if (wr && bus_addr == 3'd5) begin
            m_en     = bus_wdata[0];
            m_irq_en = bus_wdata[2];
        end
        m_irq = (m_st != 0) && m_irq_en;
        if (acc) m_busy = 1'b1;
        else if (!bus_req) m_busy = 1'b0;
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        @(negedge clk);
        chk("ack", 32'(bus_ack), 32'(m_busy));
        chk("rdata", bus_rdata, m_rdata);
        chk("irq", 32'(ovf_irq), 32'(m_irq));
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
        bus_req  = 1'b1;
        bus_we   = 1'b0;
        bus_addr = a;
        tick();
        d = bus_rdata;
        bus_req = 1'b0;
        tick();
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [31:0] v);
        bus_req   = 1'b1;
        bus_we    = 1'b1;
        bus_addr  = a;
        bus_wdata = v;
        tick();
        bus_req = 1'b0;
        bus_we  = 1'b0;
        tick();
    endtask

    initial begin
        logic [31:0] d;
        logic [31:0] c1;
        logic [31:0] c2;
        int          ac;

        rst          = 1'b0;
        instr_valid  = 1'b0;
        branch_taken = 1'b0;
        jump         = 1'b0;
        jump_reg     = 1'b0;
        bus_req      = 1'b0;
        bus_we       = 1'b0;
        bus_addr     = '0;
        bus_wdata    = '0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_ack", 32'(bus_ack), 32'd0);
        chk("rst_rdata", bus_rdata, 32'd0);
        chk("rst_irq", 32'(ovf_irq), 32'd0);
        rst = 1'b1;
        bus_read(3'd5, d);
        chk("rst_ctrl", d, 32'd1);

        // Ten retiring instructions, three taken branches.
        instr_valid = 1'b1;
        for (int k = 0; k < 10; k++) begin
            branch_taken = (k == 2 || k == 5 || k == 7);
            tick();
        end
        instr_valid  = 1'b0;
        branch_taken = 1'b0;
        bus_read(3'd0, d);
        chk("cyc_ge10", 32'(d >= 32'd10), 32'd1);
        bus_read(3'd1, d);
        chk("ins10", d, 32'd10);
        bus_read(3'd2, d);
        chk("brt3", d, 32'd3);
        bus_read(3'd3, d);
        chk("jmp0", d, 32'd0);
        bus_read(3'd4, d);
        chk("jrg0", d, 32'd0);

        // Jump strobes without a valid instruction count only cycles.
        bus_read(3'd0, c1);
        jump = 1'b1;
        repeat (5) tick();
        jump = 1'b0;
        bus_read(3'd0, c2);
        chk("cyc_delta", c2 - c1, 32'd7);
        bus_read(3'd3, d);
        chk("jmp_gated", d, 32'd0);
        bus_read(3'd1, d);
        chk("ins_gated", d, 32'd10);

        // Overflow of INS raises STATUS[1] and the interrupt.
        bus_write(3'd5, 32'd5);
        bus_write(3'd1, 32'hFFFF_FFFE);
        instr_valid = 1'b1;
        tick();
        tick();
        instr_valid = 1'b0;
        chk("irq_set", 32'(ovf_irq), 32'd1);
        bus_read(3'd1, d);
        chk("ins_wrap", d, 32'd0);
        bus_read(3'd6, d);
        chk("status_ins", d, 32'd2);
        bus_req   = 1'b1;
        bus_we    = 1'b1;
        bus_addr  = 3'd6;
        bus_wdata = 32'd2;
        tick();
        chk("irq_clr", 32'(ovf_irq), 32'd0);
        bus_req = 1'b0;
        bus_we  = 1'b0;
        tick();

        // Disabled counting, then clear-and-enable.
        bus_write(3'd5, 32'd0);
        instr_valid = 1'b1;
        jump        = 1'b1;
        repeat (8) tick();
        instr_valid = 1'b0;
        jump        = 1'b0;
        bus_read(3'd3, d);
        chk("jmp_disabled", d, 32'd0);
        bus_write(3'd5, 32'd3);
        bus_read(3'd1, d);
        chk("ins_clr", d, 32'd0);
        bus_read(3'd2, d);
        chk("brt_clr", d, 32'd0);
        bus_read(3'd5, d);
        chk("ctrl_clr_rd", d, 32'd1);

        // Bus load beats a coincident event.
        instr_valid = 1'b1;
        jump_reg    = 1'b1;
        bus_req     = 1'b1;
        bus_we      = 1'b1;
        bus_addr    = 3'd4;
        bus_wdata   = 32'd7;
        tick();
        instr_valid = 1'b0;
        jump_reg    = 1'b0;
        bus_req     = 1'b0;
        bus_we      = 1'b0;
        tick();
        bus_read(3'd4, d);
        chk("jrg_ld", d, 32'd7);

        // Long request: one access, ack held until req drops.
        bus_req  = 1'b1;
        bus_we   = 1'b0;
        bus_addr = 3'd7;
        ac       = 0;
        repeat (4) begin
            tick();
            if (bus_ack) ac++;
        end
        d       = bus_rdata;
        bus_req = 1'b0;
        tick();
        chk("hold_ack", 32'(ac), 32'd4);
        chk("hold_id", d, ID_CONST);
        chk("hold_drop", 32'(bus_ack), 32'd0);

        // Asynchronous reset during ACK.
        bus_req  = 1'b1;
        bus_addr = 3'd0;
        tick();
        rst = 1'b0;
        #1;
        chk("arst_ack", 32'(bus_ack), 32'd0);
        chk("arst_rdata", bus_rdata, 32'd0);
        model_reset();
        bus_req = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        bus_read(3'd5, d);
        chk("arst_ctrl", d, 32'd1);
        bus_read(3'd4, d);
        chk("arst_jrg", d, 32'd0);
        bus_read(3'd7, d);
        chk("id", d, ID_CONST);

        // Randomized traffic against the model.
        for (int n = 0; n < 400; n++) begin
            instr_valid  = 1'($urandom_range(0, 3) != 0);
            branch_taken = 1'($urandom_range(0, 1));
            jump         = 1'($urandom_range(0, 1));
            jump_reg     = 1'($urandom_range(0, 1));
            bus_req      = ($urandom_range(0, 99) < 50);
            bus_we       = 1'($urandom_range(0, 1));
            bus_addr     = 3'($urandom_range(0, 7));
            if (bus_addr < 3'd5 && $urandom_range(0, 1) == 1)
                bus_wdata = 32'hFFFF_FFF8 + 32'($urandom_range(0, 7));
            else if (bus_addr == 3'd5)
                bus_wdata = ($urandom & 32'h6) | 32'($urandom_range(0, 7) != 0);
            else
                bus_wdata = $urandom;
            tick();
        end
        bus_req = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
